vote_session: RTL and testbench

Clocked, parametrised voting controller: the sequential successor to the combinational majority voter. It opens a ballot session on `start` and accepts at most one vote per voter. The session closes when every voter has voted or a timeout expires, and the block then evaluates a selectable rule (simple majority, two-thirds, unanimous) against a quorum. The result is held with a valid/ack handshake and full tallies, for use by the front-panel/display logic of the voting board.

---
 rtl/vote_pkg.sv | 23 ++
 rtl/vote_session_popcount.sv | 20 ++
 rtl/vote_session.sv | 183 ++++++++++++++++++
 tb/tb_vote_session.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// vote_pkg
// Shared types and constants for the ballot controller.
//   state_t    : session FSM states
//   MODE_*     : decision rule encodings carried on the mode input
//   norm_mode  : folds the unused encoding (3) onto simple majority
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_MAJ  = 2'd0;
  localparam logic [1:0] MODE_2_3  = 2'd1;
  localparam logic [1:0] MODE_UNAN = 2'd2;

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_MAJ : m;
  endfunction

endpackage

// File: rtl/vote_session_popcount.sv
// ballot_popcount
// Combinational population count of a ballot mask.
//   mask  : W-bit mask of voters to count
//   count : number of set bits, $clog2(W+1) bits wide
module ballot_popcount #(
  parameter int W = 5,
  localparam int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  mask,
  output logic [OW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + OW'(mask[i]);
    end
  end

endmodule

// File: rtl/vote_session.sv
// vote_session
// Ballot session controller: opens on start, takes at most one vote per
// voter, closes on full ballot or timeout, then evaluates the selected
// rule against a quorum and holds the result until acknowledged.
//   clk, rst_n          : clock, async active-low reset
//   start, mode         : open a session (IDLE only) and select its rule
//   vote_valid/vote_val : per-voter vote strobe and value (1 = yes)
//   result_ack          : releases the held result (DONE only)
//   busy, result_valid  : session activity / result available
//   result_pass/tie     : decision flags
//   no_quorum/timed_out : quorum missed / closed by timeout
//   yes/no/abstain_count: final tallies
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; votes ignored
// COLLECT | accepting first vote per voter, timer running
// DECIDE  | one cycle: tallies and rule evaluated, results registered
// DONE    | result held with result_valid until result_ack
module vote_session
  import vote_pkg::*;
#(
  parameter int VOTERS  = 5,
  parameter int TIMEOUT = 16,
  parameter int QUORUM  = VOTERS / 2 + 1,
  localparam int CW = $clog2(VOTERS + 1),
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [VOTERS-1:0] vote_valid,
  input  logic [VOTERS-1:0] vote_val,
  input  logic              result_ack,
  output logic              busy,
  output logic              result_valid,
  output logic              result_pass,
  output logic              result_tie,
  output logic              no_quorum,
  output logic              timed_out,
  output logic [CW-1:0]     yes_count,
  output logic [CW-1:0]     no_count,
  output logic [CW-1:0]     abstain_count
);

  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW+1:0]   THR_2_3    = (CW + 2)'(2 * VOTERS);
  localparam logic [CW:0]     QUORUM_W   = (CW + 1)'(QUORUM);
  localparam logic [CW-1:0]   VOTERS_W   = CW'(VOTERS);

  state_t            state;
  logic [VOTERS-1:0] cast;
  logic [VOTERS-1:0] yes_mask;
  logic [1:0]        mode_q;
  logic [TW-1:0]     timer;

  logic [VOTERS-1:0] new_bits;
  logic [VOTERS-1:0] cast_nxt;
  logic [VOTERS-1:0] yes_nxt;
  logic [VOTERS-1:0] yes_cast;
  logic [VOTERS-1:0] no_cast;
  logic [CW-1:0]     y_cnt;
  logic [CW-1:0]     n_cnt;
  logic [CW-1:0]     a_cnt;
  logic [CW:0]       cast_sum;
  logic [CW+1:0]     y_x3;
  logic [1:0]        rule;
  logic              quorum_ok;
  logic              pass_rule;
  logic              tie_rule;

  // Only voters that have not yet cast load their value: first vote wins.
  assign new_bits = vote_valid & ~cast;
  assign cast_nxt = cast | new_bits;
  assign yes_nxt  = (yes_mask & ~new_bits) | (new_bits & vote_val);

  assign yes_cast = cast & yes_mask;
  assign no_cast  = cast & ~yes_mask;

  ballot_popcount #(.W(VOTERS)) u_pop_yes (
    .mask  (yes_cast),
    .count (y_cnt)
  );

  ballot_popcount #(.W(VOTERS)) u_pop_no (
    .mask  (no_cast),
    .count (n_cnt)
  );

  assign a_cnt    = VOTERS_W - y_cnt - n_cnt;
  assign cast_sum = {1'b0, y_cnt} + {1'b0, n_cnt};
  // 3*Y as Y + 2*Y, two guard bits so full membership never wraps.
  assign y_x3     = {2'b00, y_cnt} + {1'b0, y_cnt, 1'b0};
  assign rule     = norm_mode(mode_q);
  assign quorum_ok = (cast_sum >= QUORUM_W);

  always_comb begin
    pass_rule = 1'b0;
    tie_rule  = 1'b0;
    case (rule)
      MODE_2_3:  pass_rule = (y_x3 >= THR_2_3);
      MODE_UNAN: pass_rule = (y_cnt == VOTERS_W);
      default: begin
        pass_rule = (y_cnt > n_cnt);
        tie_rule  = (y_cnt == n_cnt) && (cast_sum != '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cast          <= '0;
      yes_mask      <= '0;
      mode_q        <= '0;
      timer         <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_pass   <= 1'b0;
      result_tie    <= 1'b0;
      no_quorum     <= 1'b0;
      timed_out     <= 1'b0;
      yes_count     <= '0;
      no_count      <= '0;
      abstain_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            cast     <= '0;
            yes_mask <= '0;
            timer    <= '0;
            mode_q   <= mode;
          end
        end

        COLLECT: begin
          cast     <= cast_nxt;
          yes_mask <= yes_nxt;
          timer    <= timer + 1'b1;
          // Full ballot takes priority over a timeout in the same cycle.
          if (&cast_nxt) begin
            state     <= DECIDE;
            timed_out <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state     <= DECIDE;
            timed_out <= 1'b1;
          end
        end

        DECIDE: begin
          state         <= DONE;
          result_valid  <= 1'b1;
          yes_count     <= y_cnt;
          no_count      <= n_cnt;
          abstain_count <= a_cnt;
          no_quorum     <= ~quorum_ok;
          result_pass   <= quorum_ok & pass_rule;
          result_tie    <= tie_rule;
        end

        DONE: begin
          // start is not looked at here, so ack+start only returns to IDLE.
          if (result_ack) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_session.sv
module tb_vote_session;

  localparam int V  = 5;
  localparam int T  = 16;
  localparam int Q  = V / 2 + 1;
  localparam int CW = $clog2(V + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [V-1:0]  vote_valid;
  logic [V-1:0]  vote_val;
  logic          result_ack;
  logic          busy;
  logic          result_valid;
  logic          result_pass;
  logic          result_tie;
  logic          no_quorum;
  logic          timed_out;
  logic [CW-1:0] yes_count;
  logic [CW-1:0] no_count;
  logic [CW-1:0] abstain_count;

  int checks = 0;
  int errors = 0;

  // per-cycle vote plan for the COLLECT phase (index 0 = first COLLECT cycle)
  logic [V-1:0] plan_v[$];
  logic [V-1:0] plan_l[$];

  // reference model outputs
  int exp_y, exp_n, exp_a, exp_pass, exp_tie, exp_nq, exp_to, close_cycle;

  vote_session #(.VOTERS(V), .TIMEOUT(T), .QUORUM(Q)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .vote_valid    (vote_valid),
    .vote_val      (vote_val),
    .result_ack    (result_ack),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_pass   (result_pass),
    .result_tie    (result_tie),
    .no_quorum     (no_quorum),
    .timed_out     (timed_out),
    .yes_count     (yes_count),
    .no_count      (no_count),
    .abstain_count (abstain_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Who voted first with what, when the ballot closes, and what the rule says.
  task automatic model_session(input logic [1:0] m);
    int first[V];
    int mm;
    logic [V-1:0] vv, vl;
    bit all_in;
    for (int i = 0; i < V; i++) first[i] = -1;
    close_cycle = T;
    exp_to = 1;
    for (int j = 1; j <= T; j++) begin
      vv = (j <= plan_v.size()) ? plan_v[j-1] : '0;
      vl = (j <= plan_l.size()) ? plan_l[j-1] : '0;
      for (int i = 0; i < V; i++)
        if (vv[i] && first[i] < 0) first[i] = vl[i] ? 1 : 0;
      all_in = 1'b1;
      for (int i = 0; i < V; i++)
        if (first[i] < 0) all_in = 1'b0;
      if (all_in) begin
        close_cycle = j;
        exp_to = 0;
        break;
      end
    end
    exp_y = 0;
    exp_n = 0;
    for (int i = 0; i < V; i++) begin
      if (first[i] == 1) exp_y++;
      if (first[i] == 0) exp_n++;
    end
    exp_a  = V - exp_y - exp_n;
    exp_nq = (exp_y + exp_n < Q) ? 1 : 0;
    mm = (m == 2'd3) ? 0 : int'(m);
    if (mm == 1)      exp_pass = (3 * exp_y >= 2 * V) ? 1 : 0;
    else if (mm == 2) exp_pass = (exp_y == V) ? 1 : 0;
    else              exp_pass = (exp_y > exp_n) ? 1 : 0;
    if (exp_nq == 1) exp_pass = 0;
    exp_tie = (mm == 0 && exp_y == exp_n && exp_y + exp_n > 0) ? 1 : 0;
  endtask

  task automatic check_results(input string name);
    check({name, ".yes"},      32'(yes_count),     32'(exp_y));
    check({name, ".no"},       32'(no_count),      32'(exp_n));
    check({name, ".abstain"},  32'(abstain_count), 32'(exp_a));
    check({name, ".pass"},     32'(result_pass),   32'(exp_pass));
    check({name, ".tie"},      32'(result_tie),    32'(exp_tie));
    check({name, ".noquorum"}, 32'(no_quorum),     32'(exp_nq));
    check({name, ".timedout"}, 32'(timed_out),     32'(exp_to));
  endtask

  task automatic run_session(input logic [1:0] m, input int hold, input bit ack_with_start,
                             input string name);
    model_session(m);
    // votes in the start cycle arrive while still IDLE and must be ignored
    start = 1'b1; mode = m; vote_valid = V'($urandom); vote_val = V'($urandom);
    tick();
    check({name, ".busy_rise"}, 32'(busy), 32'd1);
    check({name, ".rv_early"},  32'(result_valid), 32'd0);
    for (int j = 1; j <= close_cycle; j++) begin
      vote_valid = (j <= plan_v.size()) ? plan_v[j-1] : '0;
      vote_val   = (j <= plan_l.size()) ? plan_l[j-1] : '0;
      start = 1'($urandom_range(0, 1));
      mode  = 2'($urandom);
      tick();
      check({name, ".rv_collect"}, 32'(result_valid), 32'd0);
    end
    // DECIDE cycle: inputs are noise
    vote_valid = V'($urandom); vote_val = V'($urandom); start = 1'($urandom_range(0, 1));
    tick();
    check({name, ".rv_done"}, 32'(result_valid), 32'd1);
    check({name, ".busy_done"}, 32'(busy), 32'd1);
    check_results(name);
    for (int h = 0; h < hold; h++) begin
      vote_valid = V'($urandom); vote_val = V'($urandom);
      start = 1'($urandom_range(0, 1)); mode = 2'($urandom);
      tick();
      check({name, ".rv_hold"}, 32'(result_valid), 32'd1);
      check_results({name, ".hold"});
    end
    vote_valid = '0; vote_val = '0;
    result_ack = 1'b1; start = ack_with_start;
    tick();
    result_ack = 1'b0; start = 1'b0;
    check({name, ".busy_fall"}, 32'(busy), 32'd0);
    check({name, ".rv_fall"},   32'(result_valid), 32'd0);
    tick();
    check({name, ".idle_stay"}, 32'(busy), 32'd0);
  endtask

  task automatic set_plan1(input logic [V-1:0] v, input logic [V-1:0] l);
    plan_v = {};
    plan_l = {};
    plan_v.push_back(v);
    plan_l.push_back(l);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; vote_valid = '0; vote_val = '0; result_ack = 1'b0;
    #12;
    check("reset.busy",    32'(busy),          32'd0);
    check("reset.rv",      32'(result_valid),  32'd0);
    check("reset.pass",    32'(result_pass),   32'd0);
    check("reset.yes",     32'(yes_count),     32'd0);
    check("reset.abstain", 32'(abstain_count), 32'd0);
    check("reset.timeout", 32'(timed_out),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // votes while IDLE without start do nothing
    vote_valid = '1; vote_val = '1;
    tick();
    check("idle.busy", 32'(busy), 32'd0);
    vote_valid = '0; vote_val = '0;

    set_plan1(5'b11111, 5'b00111);
    run_session(2'd0, 0, 1'b0, "maj_full");

    set_plan1(5'b01111, 5'b00101);
    run_session(2'd0, 0, 1'b0, "maj_tie_timeout");

    plan_v = {5'b00001, 5'b00000, 5'b00001, 5'b11110};
    plan_l = {5'b00001, 5'b00000, 5'b00000, 5'b00000};
    run_session(2'd0, 0, 1'b0, "first_wins");

    set_plan1(5'b11111, 5'b00111);
    run_session(2'd1, 0, 1'b0, "twothirds_3y");
    set_plan1(5'b11111, 5'b01111);
    run_session(2'd1, 0, 1'b0, "twothirds_4y");
    set_plan1(5'b11111, 5'b11111);
    run_session(2'd2, 0, 1'b0, "unan_5y");
    set_plan1(5'b11111, 5'b01111);
    run_session(2'd2, 0, 1'b0, "unan_4y");
    set_plan1(5'b00011, 5'b00011);
    run_session(2'd0, 0, 1'b0, "no_quorum");
    set_plan1(5'b11111, 5'b01110);
    run_session(2'd3, 10, 1'b1, "hold10_mode3");

    // reset mid-COLLECT, with held results from a prior session still visible
    set_plan1(5'b11111, 5'b11111);
    run_session(2'd0, 0, 1'b0, "pre_reset");
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0; vote_valid = 5'b00011; vote_val = 5'b00011;
    tick();
    vote_valid = '0; vote_val = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.busy",    32'(busy),          32'd0);
    check("midreset.rv",      32'(result_valid),  32'd0);
    check("midreset.pass",    32'(result_pass),   32'd0);
    check("midreset.yes",     32'(yes_count),     32'd0);
    check("midreset.no",      32'(no_count),      32'd0);
    check("midreset.abstain", 32'(abstain_count), 32'd0);
    check("midreset.tie",     32'(result_tie),    32'd0);
    check("midreset.nq",      32'(no_quorum),     32'd0);
    check("midreset.to",      32'(timed_out),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("postreset.busy", 32'(busy), 32'd0);
    // masks must be clean: the two pre-reset votes must not reappear
    set_plan1(5'b11100, 5'b11100);
    run_session(2'd0, 0, 1'b0, "after_reset");

    for (int s = 0; s < 30; s++) begin
      int len;
      len = $urandom_range(1, T + 2);
      plan_v = {};
      plan_l = {};
      for (int j = 0; j < len; j++) begin
        plan_v.push_back(V'($urandom & $urandom));
        plan_l.push_back(V'($urandom));
      end
      run_session(2'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
